// File: rtl/rr_select_arbiter.sv
// Round-robin arbiter driving the select of a downstream N-input mux; grants are held until done_in.
// Optional hold-time limit enabled by defining RR_TIMEOUT_EN.
module rr_select_arbiter #(
  parameter int inputs  = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                       clk_in,
  input  logic                       rst_n_in,
  input  logic [inputs-1:0]          req_in,
  input  logic                       done_in,
  output logic [$clog2(inputs)-1:0]  s_out,
  output logic                       valid_out,
  output logic [inputs-1:0]          grant_out
);

  localparam int SW = $clog2(inputs);

  if (inputs < 2 || TIMEOUT < 1) begin : g_param_check
    $error("rr_select_arbiter: inputs must be >= 2 and TIMEOUT >= 1");
  end

  typedef enum logic {ST_IDLE = 1'b0, ST_GRANT = 1'b1} state_t;

  state_t              r_state, w_state_nxt;
  logic [SW-1:0]       r_ptr, w_ptr_nxt;
  logic [SW-1:0]       r_s, w_s_nxt;
  logic                r_valid, w_valid_nxt;
  logic [inputs-1:0]   r_grant, w_grant_nxt;
  logic                w_release;
  logic                w_timeout;
  logic [SW-1:0]       w_next_ptr;
  logic [SW-1:0]       w_arb_ptr;
  logic [SW:0]         w_arb;
  logic                w_found;
  logic [SW-1:0]       w_win;
  logic [inputs-1:0]   w_win_oh;

  // Scan ptr, ptr+1, ... wrapping at inputs-1; MSB of the result flags that a winner exists.
  function automatic logic [SW:0] f_arb(input logic [inputs-1:0] req, input logic [SW-1:0] ptr);
    logic          found;
    logic [SW-1:0] idx;
    int            j;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < inputs; k++) begin
      j = int'(ptr) + k;
      if (j >= inputs) j = j - inputs;
      if (!found && req[j]) begin
        found = 1'b1;
        idx   = SW'(j);
      end
    end
    return {found, idx};
  endfunction

  assign w_release  = (r_state == ST_GRANT) && (done_in || w_timeout);
  assign w_next_ptr = (r_s == SW'(inputs - 1)) ? '0 : r_s + SW'(1);
  // On release the just-served source drops to lowest priority in the same cycle.
  assign w_arb_ptr  = w_release ? w_next_ptr : r_ptr;
  assign w_arb      = f_arb(req_in, w_arb_ptr);
  assign w_found    = w_arb[SW];
  assign w_win      = w_arb[SW-1:0];
  assign w_win_oh   = inputs'(1) << w_win;

`ifdef RR_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] r_cnt;
  logic          w_new_grant;

  // Release on the edge where the hold count would reach TIMEOUT, giving exactly TIMEOUT grant cycles.
  assign w_timeout   = (r_state == ST_GRANT) && !done_in && (r_cnt == CW'(TIMEOUT - 1));
  assign w_new_grant = (w_state_nxt == ST_GRANT) && ((r_state == ST_IDLE) || w_release);

  // Hold counter: cleared on each new grant, counts GRANT cycles without done_in.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_cnt <= '0;
    end else if (w_new_grant) begin
      r_cnt <= '0;
    end else if ((r_state == ST_GRANT) && !done_in) begin
      r_cnt <= r_cnt + CW'(1);
    end else begin
      r_cnt <= r_cnt;
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  // Next-state and next-output logic for the IDLE/GRANT controller.
  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_s_nxt     = r_s;
    w_valid_nxt = r_valid;
    w_grant_nxt = r_grant;
    case (r_state)
      ST_IDLE: begin
        if (w_found) begin
          w_state_nxt = ST_GRANT;
          w_s_nxt     = w_win;
          w_valid_nxt = 1'b1;
          w_grant_nxt = w_win_oh;
        end else begin
          w_valid_nxt = 1'b0;
          w_grant_nxt = '0;
        end
      end
      ST_GRANT: begin
        if (w_release) begin
          w_ptr_nxt = w_next_ptr;
          if (w_found) begin
            w_s_nxt     = w_win;
            w_valid_nxt = 1'b1;
            w_grant_nxt = w_win_oh;
          end else begin
            w_state_nxt = ST_IDLE;
            w_valid_nxt = 1'b0;
            w_grant_nxt = '0;
          end
        end else begin
          w_state_nxt = ST_GRANT;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_valid_nxt = 1'b0;
        w_grant_nxt = '0;
      end
    endcase
  end

  // State, pointer and registered mux-select outputs.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_state <= ST_IDLE;
      r_ptr   <= '0;
      r_s     <= '0;
      r_valid <= 1'b0;
      r_grant <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_s     <= w_s_nxt;
      r_valid <= w_valid_nxt;
      r_grant <= w_grant_nxt;
    end
  end

  assign s_out     = r_s;
  assign valid_out = r_valid;
  assign grant_out = r_grant;

endmodule

// File: tb/tb_rr_select_arbiter.sv
// Scoreboard bench for rr_select_arbiter: a 4-input instance and a 3-input instance share clock and reset.
module tb_rr_select_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req;
  logic       done;
  logic [1:0] s;
  logic       valid;
  logic [3:0] grant;
  logic [2:0] req3;
  logic       done3;
  logic [1:0] s3;
  logic       valid3;
  logic [2:0] grant3;

  int n_checks = 0;
  int n_errors = 0;
  int q4[$];
  int q3[$];
  int e4, e3;
  logic [3:0] eg4;
  logic [2:0] eg3;

  always #5 clk = ~clk;

  rr_select_arbiter #(.inputs(4), .TIMEOUT(4)) u_dut4 (
    .clk_in(clk), .rst_n_in(rst_n), .req_in(req), .done_in(done),
    .s_out(s), .valid_out(valid), .grant_out(grant)
  );

  rr_select_arbiter #(.inputs(3), .TIMEOUT(4)) u_dut3 (
    .clk_in(clk), .rst_n_in(rst_n), .req_in(req3), .done_in(done3),
    .s_out(s3), .valid_out(valid3), .grant_out(grant3)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor for the 4-input arbiter: every live grant cycle consumes one expected index.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && valid === 1'b1) begin
      if (q4.size() == 0) begin
        check("unexpected_grant4", 32'd1, 32'd0);
      end else begin
        e4  = q4.pop_front();
        eg4 = 4'b0001 << e4;
        check("s4", 32'(s), 32'(e4));
        check("grant4", 32'(grant), 32'(eg4));
      end
    end else if (rst_n === 1'b1) begin
      check("idle_grant4_zero", 32'(grant), 32'd0);
    end
  end

  // Monitor for the 3-input arbiter.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && valid3 === 1'b1) begin
      if (q3.size() == 0) begin
        check("unexpected_grant3", 32'd1, 32'd0);
      end else begin
        e3  = q3.pop_front();
        eg3 = 3'b001 << e3;
        check("s3", 32'(s3), 32'(e3));
        check("grant3", 32'(grant3), 32'(eg3));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    req   = 4'b1111;
    done  = 1'b0;
    req3  = 3'b111;
    done3 = 1'b0;
    repeat (3) step();
    check("rst_s4", 32'(s), 32'd0);
    check("rst_valid4", 32'(valid), 32'd0);
    check("rst_grant4", 32'(grant), 32'd0);
    check("rst_valid3", 32'(valid3), 32'd0);
    req   = 4'b0000;
    req3  = 3'b000;
    rst_n = 1'b1;
    step();
    check("post_rst_idle", 32'(valid), 32'd0);

    // Single request held 5 cycles while req drops, then release to idle.
    req = 4'b0100;
    step(); q4.push_back(2);
    req = 4'b0000;
    repeat (4) begin step(); q4.push_back(2); end
    done = 1'b1;
    step();
    done = 1'b0;
    check("single_release_valid", 32'(valid), 32'd0);
    check("single_release_grant", 32'(grant), 32'd0);

    // Asynchronous reset in the middle of a grant at index 2 (ptr is 3 here).
    req = 4'b0100;
    step();
    check("midrst_pre_s", 32'(s), 32'd2);
    check("midrst_pre_valid", 32'(valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check("midrst_s", 32'(s), 32'd0);
    check("midrst_valid", 32'(valid), 32'd0);
    check("midrst_grant", 32'(grant), 32'd0);
    req = 4'b0000;
    step();
    rst_n = 1'b1;
    step();

    // Full round robin with continuous release.
    req  = 4'b1111;
    done = 1'b1;
    for (int i = 0; i < 6; i++) begin step(); q4.push_back(i % 4); end
    req = 4'b0000;
    step();
    check("rr_end_valid", 32'(valid), 32'd0);

    // Sparse back-to-back grants starting from index 2.
    done = 1'b0;
    req  = 4'b0100;
    step(); q4.push_back(2);
    req  = 4'b1011;
    done = 1'b1;
    step(); q4.push_back(3);
    step(); q4.push_back(0);
    step(); q4.push_back(1);
    req = 4'b0000;
    step();
    check("sparse_end_valid", 32'(valid), 32'd0);

    // done_in while idle must not move the pointer (still 2).
    repeat (3) step();
    check("idle_done_valid", 32'(valid), 32'd0);
    done = 1'b0;
    req  = 4'b1111;
    step(); q4.push_back(2);
    done = 1'b1;
    req  = 4'b0000;
    step();
    check("idle_done_release", 32'(valid), 32'd0);

    // Long hold: forced release every 4 cycles with the timeout, indefinite hold without it.
    done = 1'b0;
    req  = 4'b0011;
`ifdef RR_TIMEOUT_EN
    for (int i = 0; i < 12; i++) begin step(); q4.push_back(((i / 4) % 2 == 0) ? 0 : 1); end
`else
    for (int i = 0; i < 100; i++) begin step(); q4.push_back(0); end
`endif
    req  = 4'b0000;
    done = 1'b1;
    step();
    check("hold_end_valid", 32'(valid), 32'd0);
    done = 1'b0;

    // Non-power-of-2 wrap on the 3-input arbiter.
    req3  = 3'b111;
    done3 = 1'b1;
    for (int i = 0; i < 4; i++) begin step(); q3.push_back(i % 3); end
    req3 = 3'b000;
    step();
    check("np2_end_valid", 32'(valid3), 32'd0);
    done3 = 1'b0;

    step();
    check("q4_drained", 32'(q4.size()), 32'd0);
    check("q3_drained", 32'(q3.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/rr_select_arbiter.md
# rr_select_arbiter

Round-robin arbiter that produces the select index for the generic N-input 1-bit mux, which sits directly downstream of it. It accepts per-source request lines and grants exactly one source at a time. It drives the encoded index straight to the mux select and a one-hot grant back to the sources. Each grant is held stable until the granted source signals completion.

## Interface
- `inputs`, default 4: number of requesters and mux inputs; must be ≥ 2; need not be a power of 2.
- `TIMEOUT`, default 16: maximum cycles a grant may be held; used only when `RR_TIMEOUT_EN` is defined; must be ≥ 1.
- `clk_in`, input, 1: single clock; all state changes on the rising edge.
- `rst_n_in`, input, 1: reset, asynchronous, active-low.
- `req_in`, input, `inputs`: request per source; bit i corresponds to mux data input i.
- `done_in`, input, 1: the current grantee releases the grant; sampled only in GRANT.
- `s_out`, output, `$clog2(inputs)`: registered encoded grant index; connects to the mux select.
- `valid_out`, output, 1: registered; `s_out` is a live grant.
- `grant_out`, output, `inputs`: registered one-hot grant; all zero when `valid_out`=0.

## Operation
- Two-state FSM: IDLE and GRANT. A round-robin pointer `ptr` (width of `s_out`) names the highest-priority index.
- **Reset state:** state=IDLE, `ptr`=0, `s_out`=0, `valid_out`=0, `grant_out`=0. Reset takes effect immediately, including mid-grant.
- **Arbitration:**
  - Choose the first set bit of `req_in` scanning `ptr`, `ptr`+1, …, `inputs`-1, 0, …, `ptr`-1.
  - Wrap is at `inputs`-1 → 0, not at the next power of 2.
  - Indices ≥ `inputs` are never produced.
- **IDLE:**
  - If `req_in`≠0: register the arbitration winner into `s_out`, set the matching `grant_out` bit, set `valid_out`=1, go to GRANT.
  - Otherwise remain in IDLE with outputs cleared.
  - `s_out` keeps its last value while idle.
- **GRANT:**
  - `s_out`, `grant_out` and `valid_out` are held constant.
  - `req_in` is ignored, including deassertion by the grantee, until `done_in`=1.
- **Release on `done_in`=1 in GRANT:**
  - Set `ptr` = (`s_out`+1) mod `inputs`.
  - Arbitrate `req_in` against the new `ptr` in the same cycle, so the just-released source has lowest priority.
  - If any request is pending: load the new winner and stay in GRANT, giving back-to-back grants with no idle cycle.
  - Otherwise: clear `valid_out`/`grant_out` and go to IDLE.
- `done_in` in IDLE has no effect.
- `ptr` advances only on release, never on an idle cycle.

## Timing
- Request to grant: 1 cycle. `req_in` is sampled at edge k; `valid_out`/`s_out` are valid after edge k.
- Release to next grant: 0 idle cycles. The new `s_out` appears after the same edge that samples `done_in`.
- Release with no pending requests: `valid_out` falls after the edge that samples `done_in`.
- All outputs are registered, with no combinational path from inputs to outputs. This makes the mux select glitch-free.
- Minimum grant length is 1 cycle (`done_in` high in the first GRANT cycle).

## Configuration
- Macro: `RR_TIMEOUT_EN`.
- **Defined:**
  - A hold counter clears on every new grant and increments each GRANT cycle in which `done_in`=0.
  - The counter is `$clog2(TIMEOUT+1)` bits wide.
  - When the counter reaches `TIMEOUT`, the arbiter performs a forced release identical to a `done_in` release: `ptr` advances and it re-arbitrates or returns to IDLE.
  - The counter resets to 0 on reset.
- **Not defined:** there is no counter and no `TIMEOUT` logic. A grant is held indefinitely until `done_in`.

## Test plan
1. **Reset:** `rst_n_in`=0 with `req_in`=4'b1111 → `s_out`=0, `valid_out`=0, `grant_out`=0. Then assert `rst_n_in`=0 mid-grant (`s_out`=2) → all outputs clear immediately, before the next clock edge.
2. **Single request:** `req_in`=4'b0100 at edge 0 → after edge 0, `valid_out`=1, `s_out`=2, `grant_out`=4'b0100. These are held for 5 cycles with `done_in`=0 even if `req_in` drops to 0. `done_in`=1 with `req_in`=0 → IDLE, `valid_out`=0.
3. **Round robin:** `req_in`=4'b1111 held, `done_in`=1 every cycle → `s_out` sequence 0,1,2,3,0,1; `valid_out` stays 1 with no gaps.
4. **Sparse back-to-back:** grant at index 2, then `req_in`=4'b1011 with `done_in`=1 → `s_out`=3, then 0, then 1 on successive releases.
5. **Non-power-of-2:** `inputs`=3, `req_in`=3'b111, continuous `done_in` → `s_out` sequence 0,1,2,0. The value 3 never appears.
6. **Timeout:** with `RR_TIMEOUT_EN` defined and `TIMEOUT`=4, `req_in`=4'b0011 and `done_in`=0 → `s_out`=0 for 4 cycles, then 1 for 4 cycles, then 0. Without the macro, `s_out`=0 persists for 100 cycles.
